// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit: opcodes, instruction field
// positions and the issue FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_NOT   = 3'b100;
  localparam logic [2:0] OP_LOADI = 3'b101;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // Opcodes forwarded unchanged to the external ALU.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// Register file for the issue unit: async-reset flops, one write port and
// three combinational read ports (two operands plus debug).
module issue_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          reg_q <= wdata;
        end
      end

      assign regs[gi] = reg_q;
    end
  endgenerate

  // Reads see the pre-write value during the write cycle.
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Multi-cycle issue/writeback controller: accepts an instruction, reads
// operands, drives the external ALU and writes the result back.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              illegal,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic              pend_zero_q, pend_zero_d;
  logic              zero_flag_q, zero_flag_d;
  logic              illegal_q, illegal_d;

  logic [2:0]        op, rd, rs1, rs2;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  assign op  = instr_q[OP_MSB:OP_LSB];
  assign rd  = instr_q[RD_MSB:RD_LSB];
  assign rs1 = instr_q[RS1_MSB:RS1_LSB];
  assign rs2 = instr_q[RS2_MSB:RS2_LSB];

  issue_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (3)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state_q == ST_WB),
    .waddr    (wb_addr_q),
    .wdata    (wb_data_q),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_raddr),
    .dbg_data (dbg_rdata)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    wb_data_d   = wb_data_q;
    wb_addr_d   = wb_addr_q;
    pend_zero_d = pend_zero_q;
    zero_flag_d = zero_flag_q;
    illegal_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu_op(op)) begin
          alu_a_d   = rs1_data;
          alu_b_d   = rs2_data;
          alu_op_d  = op;
          wb_addr_d = rd;
          state_d   = ST_EXEC;
        end else if (op == OP_LOADI) begin
          wb_data_d = {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_W-1:0]};
          wb_addr_d = rd;
          state_d   = ST_WB;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        wb_data_d   = alu_result;
        pend_zero_d = alu_zero;
        state_d     = ST_WB;
      end
      ST_WB: begin
        // LOADI leaves the flag from the last ALU instruction untouched.
        if (is_alu_op(op)) begin
          zero_flag_d = pend_zero_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      wb_data_q   <= '0;
      wb_addr_q   <= '0;
      pend_zero_q <= 1'b0;
      zero_flag_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      wb_data_q   <= wb_data_d;
      wb_addr_q   <= wb_addr_d;
      pend_zero_q <= pend_zero_d;
      zero_flag_q <= zero_flag_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE) && rst_n;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign wb_valid    = (state_q == ST_WB);
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign zero_flag   = zero_flag_q;
  assign illegal     = illegal_q;

endmodule
